pkmc_wbdma: RTL and testbench

Wishbone initiator that copies a block of 32-bit words from a source address to a destination address, one single-word read followed by one single-word write per word. It is the master-side counterpart of the memory controller slaves (SRAM, SDRAM, flash) on the shared Wishbone bus. Software-side or test logic drives a simple start/len/src/dst control interface. The block reports busy, done and error.

---
 rtl/pkmc_wbdma_defines.sv | 22 ++
 rtl/pkmc_wbdma_wdog.sv | 33 +++
 rtl/pkmc_wbdma.sv | 216 +++++++++++++++++++++
 tb/tb_pkmc_wbdma.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkmc_wbdma_defines.sv
// Shared definitions for the Wishbone block-copy initiator:
// FSM state encoding, byte-lane select constant and word address step.
package pkmc_wbdma_defines;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_RGAP = 3'd2,
    ST_WR   = 3'd3,
    ST_WGAP = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam logic [3:0]  SEL_ALL  = 4'hF;
  localparam logic [31:0] ADDR_INC = 32'd4;

  // Byte addresses are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pkmc_wbdma_wdog.sv
// Loadable down-counter used as the bus wait watchdog. It is reloaded
// while no strobe is outstanding and counts down while one is; the
// timeout output is raised in the strobe cycle where the count is zero.
module pkmc_wbdma_wdog #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_timeout
);

  logic [CNT_W-1:0] r_cnt;

  // Clear beats load beats count; the counter saturates at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_timeout = i_en && (r_cnt == '0);

endmodule

// File: rtl/pkmc_wbdma.sv
// Wishbone block-copy initiator: for each word, one single read from the
// source pointer followed by one single write to the destination pointer,
// with one idle bus cycle after every access.
//
// Bus handshake: an access is outstanding while wb_cyc_o/wb_stb_o are high;
// it ends in the first clock edge where the slave raises ack, err or rty
// (err > ack > rty). All bus outputs are registers, so nothing on the bus
// depends combinationally on the slave's termination inputs.
module pkmc_wbdma
  import pkmc_wbdma_defines::*;
#(
  parameter int LEN_W    = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic [31:0]      src_i,
  input  logic [31:0]      dst_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] cnt_o,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  output logic [3:0]       wb_sel_o,
  output logic             wb_we_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  input  logic             wb_rty_i,
  output logic [2:0]       dbg_state_o
);

  localparam int WD_W = $clog2(MAX_WAIT + 1);

  state_e           r_state;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0]      r_data;
  logic [31:0]      r_adr;
  logic             r_cyc;
  logic             r_we;
  logic             r_retry;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_in_stb;
  logic             w_wd_load;
  logic             w_wd_clr;
  logic             w_timeout;

  // The watchdog is armed in every non-strobe state so each entry to RD or
  // WR starts a fresh MAX_WAIT window; stb cycle k sees MAX_WAIT-k.
  assign w_in_stb  = (r_state == ST_RD) || (r_state == ST_WR);
  assign w_wd_clr  = (r_state == ST_DONE);
  assign w_wd_load = (r_state == ST_IDLE) || (r_state == ST_RGAP) ||
                     (r_state == ST_WGAP);

  pkmc_wbdma_wdog #(
    .CNT_W (WD_W)
  ) u_wdog (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_clr      (w_wd_clr),
    .i_load     (w_wd_load),
    .i_load_val (WD_W'(MAX_WAIT - 1)),
    .i_en       (w_in_stb),
    .o_timeout  (w_timeout)
  );

  // Copy FSM; every output is registered alongside the state.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_adr   <= '0;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_retry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_err <= 1'b0;
            r_cnt <= '0;
            if (len_i != '0) begin
              r_src   <= word_align(src_i);
              r_dst   <= word_align(dst_i);
              r_len   <= len_i;
              r_retry <= 1'b0;
              r_busy  <= 1'b1;
              r_adr   <= word_align(src_i);
              r_we    <= 1'b0;
              r_cyc   <= 1'b1;
              r_state <= ST_RD;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_RD: begin
          if (wb_err_i) begin
            r_err   <= 1'b1;
            r_cyc   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else if (wb_ack_i) begin
            r_data  <= wb_dat_i;
            r_cyc   <= 1'b0;
            r_state <= ST_RGAP;
          end else if (wb_rty_i) begin
            r_retry <= 1'b1;
            r_cyc   <= 1'b0;
            r_state <= ST_RGAP;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_cyc   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_RGAP: begin
          r_cyc   <= 1'b1;
          r_retry <= 1'b0;
          if (r_retry) begin
            r_adr   <= r_src;
            r_we    <= 1'b0;
            r_state <= ST_RD;
          end else begin
            r_adr   <= r_dst;
            r_we    <= 1'b1;
            r_state <= ST_WR;
          end
        end
        ST_WR: begin
          if (wb_err_i) begin
            r_err   <= 1'b1;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else if (wb_ack_i) begin
            r_cnt   <= r_cnt + LEN_W'(1);
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= ST_WGAP;
          end else if (wb_rty_i) begin
            r_retry <= 1'b1;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= ST_WGAP;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_WGAP: begin
          r_retry <= 1'b0;
          if (r_retry) begin
            r_adr   <= r_dst;
            r_we    <= 1'b1;
            r_cyc   <= 1'b1;
            r_state <= ST_WR;
          end else if (r_cnt == r_len) begin
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_src   <= r_src + ADDR_INC;
            r_dst   <= r_dst + ADDR_INC;
            r_adr   <= r_src + ADDR_INC;
            r_we    <= 1'b0;
            r_cyc   <= 1'b1;
            r_state <= ST_RD;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign cnt_o       = r_cnt;
  assign wb_adr_o    = r_adr;
  assign wb_dat_o    = r_data;
  assign wb_sel_o    = SEL_ALL;
  assign wb_we_o     = r_we;
  assign wb_cyc_o    = r_cyc;
  assign wb_stb_o    = r_cyc;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pkmc_wbdma.sv
// Bench for the Wishbone block-copy initiator: a behavioural slave with
// configurable wait states / retry / error / no-response, a table of
// directed transfers, hand sequences for abort and reset corners, and
// randomized transfers checked against an arithmetic copy model.
module tb_pkmc_wbdma;

  localparam int LEN_W    = 16;
  localparam int MAX_WAIT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc_ctr = 0;
  always @(posedge clk) cyc_ctr++;

  // ---------------- DUT ----------------
  logic             start_i = 1'b0;
  logic [31:0]      src_i = '0;
  logic [31:0]      dst_i = '0;
  logic [LEN_W-1:0] len_i = '0;
  logic             busy_o, done_o, err_o;
  logic [LEN_W-1:0] cnt_o;
  logic [31:0]      wb_adr_o, wb_dat_o;
  logic [31:0]      wb_dat_i = '0;
  logic [3:0]       wb_sel_o;
  logic             wb_we_o, wb_cyc_o, wb_stb_o;
  logic             wb_ack_i = 1'b0;
  logic             wb_err_i = 1'b0;
  logic             wb_rty_i = 1'b0;
  logic [2:0]       dbg_state_o;

  pkmc_wbdma #(.LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .start_i     (start_i),
    .src_i       (src_i),
    .dst_i       (dst_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .cnt_o       (cnt_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_dat_i    (wb_dat_i),
    .wb_sel_o    (wb_sel_o),
    .wb_we_o     (wb_we_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i),
    .wb_rty_i    (wb_rty_i),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int bus_bad = 0;

  logic [63:0] exp_q[$];      // expected writes {adr, data}
  logic [63:0] wr_q[$];       // observed writes {adr, data}
  logic [31:0] acc_adr_q[$];
  logic        acc_we_q[$];
  int          acc_start_q[$];
  int          hold_q[$];

  // slave behaviour knobs
  int waits  = 0;
  int rty_on = -1;
  int err_on = -1;
  bit dead   = 1'b0;
  int acc_n  = 0;
  int cur    = 0;
  int hold   = 0;
  int max_hold = 0;

  // Source memory contents: three fixed words at 0x1000, a pattern elsewhere.
  function automatic logic [31:0] src_word(input logic [31:0] a);
    if (a == 32'h1000) return 32'hA0;
    if (a == 32'h1004) return 32'hA1;
    if (a == 32'h1008) return 32'hA2;
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  // Responds at the falling edge so the DUT samples a stable termination.
  always @(negedge clk) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    if (wb_cyc_o !== wb_stb_o) bus_bad++;
    if (wb_cyc_o && (wb_sel_o !== 4'hF)) bus_bad++;
    if (wb_adr_o[1:0] !== 2'b00) bus_bad++;
    if (rst) begin
      hold = 0;
    end else if (wb_cyc_o && wb_stb_o) begin
      if (hold == 0) begin
        cur = acc_n;
        acc_n++;
        acc_adr_q.push_back(wb_adr_o);
        acc_we_q.push_back(wb_we_o);
        acc_start_q.push_back(cyc_ctr);
      end
      hold++;
      if (hold > max_hold) max_hold = hold;
      if (!dead) begin
        if (cur == err_on) begin
          wb_err_i = 1'b1;
        end else if (hold > waits) begin
          if (cur == rty_on) begin
            wb_rty_i = 1'b1;
          end else begin
            wb_ack_i = 1'b1;
            if (wb_we_o) wr_q.push_back({wb_adr_o, wb_dat_o});
            else         wb_dat_i = src_word(wb_adr_o);
          end
        end
      end
      if (wb_ack_i || wb_err_i || wb_rty_i) begin
        hold_q.push_back(hold);
        hold = 0;
      end
    end else begin
      hold = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    exp_q.delete();
    wr_q.delete();
    acc_adr_q.delete();
    acc_we_q.delete();
    acc_start_q.delete();
    hold_q.delete();
    acc_n    = 0;
    max_hold = 0;
  endtask

  // Pulse start for one cycle; lat = cycles from the start edge to the
  // cycle where done_o is seen (-1 if it never comes).
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d,
                          input logic [LEN_W-1:0] l, output int lat, output logic busy1);
    clear_logs();
    @(negedge clk);
    src_i = s; dst_i = d; len_i = l; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    lat = -1;
    busy1 = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = busy_o;
      if (done_o) begin
        lat = k;
        break;
      end
    end
  endtask

  // Reference model: a word-by-word copy with modulo-2^32 pointers.
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int l);
    logic [31:0] sa, da;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    for (int i = 0; i < l; i++) begin
      exp_q.push_back({da, src_word(sa)});
      sa = sa + 32'd4;
      da = da + 32'd4;
    end
  endtask

  task automatic compare_writes(input string name);
    check({name, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check({name, "_wr"}, wr_q[i], exp_q[i]);
  endtask

  // Latency of a clean copy: start edge, 4 + 2*waits per word, DONE.
  function automatic int model_lat(input int l, input int w);
    return (l == 0) ? 2 : l * (4 + 2 * w) + 2;
  endfunction

  typedef struct {
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    int               waits;
    int               exp_lat;
    logic [LEN_W-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          lat;
    logic        busy1;
    int          dsum;
    logic [31:0] s, d;
    int          l;

    vecs[0] = '{32'h0000_1000, 32'h0000_2000, 16'd3, 0, 14, 16'd3};
    vecs[1] = '{32'h0000_1000, 32'h0000_2000, 16'd0, 0,  2, 16'd0};
    vecs[2] = '{32'h0000_1000, 32'h0000_4000, 16'd2, 3, 22, 16'd2};
    vecs[3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 16'd3, 0, 14, 16'd3};
    vecs[4] = '{32'h0000_1003, 32'h0000_2002, 16'd1, 1,  8, 16'd1};

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_cyc",   64'(wb_cyc_o), 64'd0);
    check("rst_busy",  64'(busy_o),   64'd0);
    check("rst_done",  64'(done_o),   64'd0);
    check("rst_err",   64'(err_o),    64'd0);
    check("rst_cnt",   64'(cnt_o),    64'd0);
    check("rst_adr",   64'(wb_adr_o), 64'd0);
    check("rst_state", 64'(dbg_state_o), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---- table-driven transfers ----
    for (int v = 0; v < 5; v++) begin
      waits = vecs[v].waits; rty_on = -1; err_on = -1; dead = 1'b0;
      run_xfer(vecs[v].src, vecs[v].dst, vecs[v].len, lat, busy1);
      model_copy(vecs[v].src, vecs[v].dst, int'(vecs[v].len));
      check("vec_lat",  64'(lat),    64'(vecs[v].exp_lat));
      check("vec_cnt",  64'(cnt_o),  64'(vecs[v].exp_cnt));
      check("vec_err",  64'(err_o),  64'd0);
      check("vec_busy1", 64'(busy1), 64'(vecs[v].len != 0));
      check("vec_busy_end", 64'(busy_o), 64'd0);
      compare_writes("vec");
      check("vec_nacc", 64'(acc_adr_q.size()), 64'(2 * int'(vecs[v].len)));
      foreach (hold_q[i]) check("vec_hold", 64'(hold_q[i]), 64'(vecs[v].waits + 1));
      @(negedge clk);
      check("vec_done_pulse", 64'(done_o), 64'd0);
    end

    // ---- retry on first read ----
    waits = 0; rty_on = 0; err_on = -1; dead = 1'b0;
    run_xfer(32'h1000, 32'h3000, 16'd1, lat, busy1);
    rty_on = -1;
    model_copy(32'h1000, 32'h3000, 1);
    check("rty_lat", 64'(lat), 64'd8);
    check("rty_cnt", 64'(cnt_o), 64'd1);
    check("rty_err", 64'(err_o), 64'd0);
    compare_writes("rty");
    check("rty_nacc", 64'(acc_adr_q.size()), 64'd3);
    if (acc_adr_q.size() == 3) begin
      check("rty_adr0", 64'(acc_adr_q[0]), 64'h1000);
      check("rty_adr1", 64'(acc_adr_q[1]), 64'h1000);
      check("rty_we1",  64'(acc_we_q[1]),  64'd0);
      check("rty_gap",  64'(acc_start_q[1] - acc_start_q[0]), 64'd2);
      check("rty_adr2", 64'(acc_adr_q[2]), 64'h3000);
    end

    // ---- error on the second write, then restart clears err ----
    waits = 0; rty_on = -1; err_on = 3; dead = 1'b0;
    run_xfer(32'h1000, 32'h5000, 16'd4, lat, busy1);
    err_on = -1;
    check("err_lat", 64'(lat), 64'd9);
    check("err_flag", 64'(err_o), 64'd1);
    check("err_cnt", 64'(cnt_o), 64'd1);
    check("err_nwr", 64'(wr_q.size()), 64'd1);
    run_xfer(32'h1000, 32'h5000, 16'd0, lat, busy1);
    check("err_clear", 64'(err_o), 64'd0);
    check("err_clear_lat", 64'(lat), 64'd2);

    // ---- unresponsive slave: watchdog timeout ----
    waits = 0; dead = 1'b1;
    run_xfer(32'h1000, 32'h6000, 16'd1, lat, busy1);
    dead = 1'b0;
    check("to_lat", 64'(lat), 64'd10);
    check("to_hold", 64'(max_hold), 64'(MAX_WAIT));
    check("to_err", 64'(err_o), 64'd1);
    check("to_cnt", 64'(cnt_o), 64'd0);

    // ---- reset asserted during a write ----
    waits = 2;
    clear_logs();
    @(negedge clk);
    src_i = 32'h1000; dst_i = 32'h7000; len_i = 16'd2; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    begin
      bit seen_wr;
      seen_wr = 1'b0;
      for (int k = 0; k < 50 && !seen_wr; k++) begin
        @(negedge clk);
        if (wb_cyc_o && wb_we_o) seen_wr = 1'b1;
      end
      check("rstwr_reached", 64'(seen_wr), 64'd1);
    end
    rst = 1'b1;
    #1;
    check("rstwr_cyc",  64'(wb_cyc_o), 64'd0);
    check("rstwr_stb",  64'(wb_stb_o), 64'd0);
    check("rstwr_we",   64'(wb_we_o),  64'd0);
    check("rstwr_busy", 64'(busy_o),   64'd0);
    check("rstwr_cnt",  64'(cnt_o),    64'd0);
    check("rstwr_dat",  64'(wb_dat_o), 64'd0);
    check("rstwr_adr",  64'(wb_adr_o), 64'd0);
    check("rstwr_state", 64'(dbg_state_o), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dsum = 0;
    repeat (10) begin
      @(negedge clk);
      dsum += int'(done_o) + int'(wb_cyc_o);
    end
    check("rstwr_quiet", 64'(dsum), 64'd0);

    // ---- randomized transfers against the copy model ----
    for (int t = 0; t < 16; t++) begin
      waits  = $urandom_range(0, 3);
      rty_on = -1; err_on = -1; dead = 1'b0;
      l = $urandom_range(0, 6);
      if ($urandom_range(0, 3) == 0) s = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else s = 32'h0001_0000 | 32'($urandom_range(0, 32'hFFFF));
      d = 32'h0800_0000 | 32'($urandom_range(0, 32'hFFFF));
      run_xfer(s, d, LEN_W'(l), lat, busy1);
      model_copy(s, d, l);
      check("rnd_lat", 64'(lat), 64'(model_lat(l, waits)));
      check("rnd_cnt", 64'(cnt_o), 64'(l));
      check("rnd_err", 64'(err_o), 64'd0);
      compare_writes("rnd");
    end

    check("bus_protocol", 64'(bus_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
